// File: rtl/pyth_triple_src.sv
// rtl/pyth_triple_src.sv - multiplier-free Pythagorean triple source over legs 1 <= a < b <= MAX_LEG.
// Optional PYTH_PRIMITIVE_ONLY_EN: emit only primitive triples (subtractive GCD filter).
module pyth_triple_src #(
  parameter int W       = 8,
  parameter int MAX_LEG = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_a,
  output logic [W-1:0]   out_b,
  output logic [W:0]     out_c,
  output logic [15:0]    count
);

  localparam int SW = 2*W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PAIR, S_SEARCH, S_FILTER, S_EMIT, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]  a, b;
  logic [W:0]    c;
  logic [SW-1:0] asq, bsq, csq, target;

  logic [W:0]    a_inc, b_inc;
  logic [SW-1:0] asq_inc, bsq_inc, a1sq;
  logic          wrap, last_a;

`ifdef PYTH_PRIMITIVE_ONLY_EN
  logic [W-1:0]  ga, gb;
`endif

  // Squares advance by (n+1)^2 = n^2 + 2n + 1; {n,1'b1} is 2n+1.
  always_comb begin
    b_inc   = {1'b0, b} + 1'b1;
    bsq_inc = bsq + SW'({b, 1'b1});
    a_inc   = {1'b0, a} + 1'b1;
    asq_inc = asq + SW'({a, 1'b1});
    a1sq    = asq_inc + SW'({a_inc, 1'b1});
    wrap    = b_inc > (W+1)'(MAX_LEG);
    last_a  = wrap && (a_inc >= (W+1)'(MAX_LEG));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    busy      = 1'b1;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:   begin busy = 1'b0; if (start) state_nx = S_INIT; end
      S_DONE:   begin busy = 1'b0; done = 1'b1; if (start) state_nx = S_INIT; end
      S_INIT:   state_nx = S_PAIR;
      S_PAIR:   state_nx = S_SEARCH;
      S_SEARCH: begin
        if (csq == target)     state_nx = S_FILTER;
        else if (csq > target) state_nx = S_NEXT;
      end
`ifdef PYTH_PRIMITIVE_ONLY_EN
      S_FILTER: if (ga == gb) state_nx = (ga == W'(1)) ? S_EMIT : S_NEXT;
`else
      S_FILTER: state_nx = S_EMIT;
`endif
      S_EMIT:   begin out_valid = 1'b1; if (out_ready) state_nx = S_NEXT; end
      S_NEXT:   state_nx = last_a ? S_DONE : S_PAIR;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0; b <= '0; c <= '0;
      asq <= '0; bsq <= '0; csq <= '0; target <= '0;
      out_a <= '0; out_b <= '0; out_c <= '0;
      count <= '0;
`ifdef PYTH_PRIMITIVE_ONLY_EN
      ga <= '0; gb <= '0;
`endif
    end else begin
      case (state)
        S_INIT: begin
          a <= W'(1); b <= W'(2);
          asq <= SW'(1); bsq <= SW'(4);
          count <= '0;
        end
        S_PAIR: begin
          target <= asq + bsq;
          c      <= b_inc;
          csq    <= bsq_inc;
`ifdef PYTH_PRIMITIVE_ONLY_EN
          ga <= a; gb <= b;
`endif
        end
        S_SEARCH: begin
          if (csq < target) begin
            csq <= csq + SW'({c, 1'b1});
            c   <= c + 1'b1;
          end
        end
        S_FILTER: begin
`ifdef PYTH_PRIMITIVE_ONLY_EN
          if (ga > gb)      ga <= ga - gb;
          else if (gb > ga) gb <= gb - ga;
`endif
          if (state_nx == S_EMIT) begin
            out_a <= a; out_b <= b; out_c <= c;
          end
        end
        S_EMIT: begin
          if (out_ready && count != 16'hFFFF) count <= count + 1'b1;
        end
        S_NEXT: begin
          if (wrap) begin
            a   <= a_inc[W-1:0];
            asq <= asq_inc;
            b   <= W'(a_inc + 1'b1);
            bsq <= a1sq;
          end else begin
            b   <= b_inc[W-1:0];
            bsq <= bsq_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pyth_triple_src.md
# pyth_triple_src

Sequential source of Pythagorean triples (a, b, c) with a² + b² = c², enumerated over all leg pairs 1 ≤ a < b ≤ MAX_LEG. Drives a valid/ready stream into parameter-checking and triple-checking benches, the producing end of the A/B/C triple relation those checkers consume. Uses no multipliers: all squares are maintained incrementally with adders.

## Interface
- W, default 8: leg width in bits. MAX_LEG must fit in W bits.
- MAX_LEG, default 20: largest leg enumerated. Legal range is 2 .. 2^W−1.
- clk  in  1: the only clock. Every register updates on the rising edge.
- rst  in  1: reset, synchronous and active-high.
- start  in  1: one-cycle pulse that begins enumeration. Honoured only in IDLE or DONE.
- busy  out  1: high in every state except IDLE and DONE.
- done  out  1: high in DONE. Stays high until start or rst.
- out_valid  out  1: a triple is presented.
- out_ready  in  1: sink accepts the presented triple.
- out_a  out  W: short leg.
- out_b  out  W: long leg.
- out_c  out  W+1: hypotenuse.
- count  out  16: number of triples accepted since the last start. Saturates at 0xFFFF.

## Operation
- Reset values: state IDLE; busy, done, out_valid = 0; out_a, out_b, out_c, count = 0.
- Internal registers:
  - a, b (W bits) and c (W+1 bits).
  - asq, bsq, csq and target = asq + bsq, each 2W+1 bits.
- States:
  - IDLE: on start go to INIT.
  - DONE: on start go to INIT.
  - INIT:
    - a=1, b=2, asq=1, bsq=4.
    - count cleared.
    - Go to PAIR.
  - PAIR:
    - target = asq + bsq.
    - c = b+1, csq = bsq + 2b + 1.
    - Go to SEARCH.
  - SEARCH, one comparison per cycle:
    - csq == target: go to FILTER.
    - csq > target: go to NEXT.
    - otherwise: csq += 2c+1, then c += 1.
  - FILTER: goes straight to EMIT, unless the filter below is compiled in.
  - EMIT:
    - out_valid=1. out_a/b/c hold a, b, c and stay stable until the handshake.
    - On out_valid && out_ready: count += 1, out_valid drops next cycle, go to NEXT.
  - NEXT:
    - bsq += 2b+1, then b += 1.
    - If the new b > MAX_LEG: asq += 2a+1, a += 1, b = a+1, bsq = (a+1)², all computed incrementally from the new a.
    - If the new a ≥ MAX_LEG: go to DONE. Otherwise go to PAIR.
- Output order: ascending a, then ascending b. Each pair (a, b) is emitted at most once.
- Arithmetic never wraps. With 2W+1-bit squares the worst case (2·MAX_LEG²) fits.
- start while busy: ignored.
- rst at any cycle, mid-EMIT included: returns to IDLE with reset values next cycle. The pending triple is dropped and not counted.
- MAX_LEG < 3: enumeration reaches DONE with count=0 and out_valid never asserted.

## Timing
- start → busy high: 1 cycle.
- PAIR takes 1 cycle. SEARCH takes (c_final − b) cycles. FILTER takes 1 cycle when the filter is compiled out.
- EMIT lasts at least 1 cycle; out_valid may be held indefinitely by out_ready=0.
- Back-to-back emission is impossible. After each accept, out_valid is low for at least 3 cycles (NEXT, PAIR, SEARCH).
- done rises in the cycle after the final NEXT and busy falls in the same cycle.
- count is updated in the cycle after the accepting edge.

## Configuration
- PYTH_PRIMITIVE_ONLY_EN defined:
  - FILTER runs a subtractive GCD on (a, b): one subtract per cycle, done when the operands are equal.
  - Go to EMIT only if gcd == 1; otherwise go to NEXT.
  - The GCD takes at most b cycles.
- PYTH_PRIMITIVE_ONLY_EN undefined: FILTER is a 1-cycle pass-through, GCD logic is absent, and all triples are emitted.

## Test plan
- Macro off, MAX_LEG=20, out_ready=1, start pulse.
  - Required: exactly (3,4,5), (5,12,13), (6,8,10), (8,15,17), (9,12,15), (12,16,20), (15,20,25) in that order.
  - Then done=1, count=7.
- Macro on, MAX_LEG=20: exactly (3,4,5), (5,12,13), (8,15,17), then count=3.
- Backpressure: hold out_ready=0 for 10 cycles on (3,4,5).
  - out_valid and outputs stay stable throughout.
  - count stays 0 until the accept, then becomes 1.
- Assert rst during EMIT of (5,12,13):
  - Next cycle: out_valid=0, busy=0, count=0.
  - A new start replays from (3,4,5).
- Pulse start again while busy: no effect on sequence or count. After DONE, start re-enumerates with count reset.
- MAX_LEG=2: done asserts with count=0 and out_valid never high.
